pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//   Control end of the 5-stage pipeline register chain: decides each cycle whether every
//   stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB) loads, holds, or loads a bubble.
//   Consumes I-cache/D-cache response handshakes, the ID-stage source registers, the EX-stage
//   load destination and the EX-stage branch decision. Drives load/flush/bubble and imem_read.
// PARAMETERS
//   REG_ADDR_W  5   register-index width (x0..x31)
//   CNT_W       32  width of each perf counter (PIPE_PERF_EN only)
// PORTS
//   clk            in   1           clock, all state on rising edge
//   reset          in   1           synchronous, active-high
//   imem_resp      in   1           I-cache returns fetch data this cycle
//   dmem_req       in   1           MEM-stage instr is a load/store (mem_read|mem_write)
//   dmem_resp      in   1           D-cache completes MEM-stage access this cycle
//   id_rs1         in   REG_ADDR_W  ID-stage rs1 index
//   id_rs2         in   REG_ADDR_W  ID-stage rs2 index
//   id_uses_rs1    in   1           ID instr reads rs1
//   id_uses_rs2    in   1           ID instr reads rs2
//   ex_mem_read    in   1           EX-stage instr is a load
//   ex_rd          in   REG_ADDR_W  EX-stage destination index
//   ex_br_taken    in   1           EX-stage branch/jump redirects PC
//   imem_read      out  1           fetch request at current PC
//   load_pc        out  1           PC register loads
//   load_if_id     out  1           IF/ID register loads
//   load_id_ex     out  1           ID/EX register loads
//   load_ex_mem    out  1           EX/MEM register loads
//   load_mem_wb    out  1           MEM/WB register loads
//   flush_if_id    out  1           IF/ID loads NOP (0x00000013) / zero control word
//   bubble_id_ex   out  1           ID/EX loads all-zero control word
//   stall          out  1           pipeline held this cycle (= ~advance)
// BEHAVIOUR
//   State: RUN / STALL (reg), i_done_q, d_done_q (1 bit each). Reset -> RUN, flags 0.
//   While reset=1 every output is 0. First cycle after reset: imem_read=1.
//   i_ok = imem_resp | i_done_q;  d_ok = ~dmem_req | dmem_resp | d_done_q;  advance = i_ok & d_ok.
//   imem_read = ~reset & ~i_done_q (exactly one request per stall window; no re-request).
//   hazard = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
//   Priority when advance=1 (combinational, same cycle):
//     1. ex_br_taken: all load_*=1, flush_if_id=1, bubble_id_ex=1 (kills both wrong-path instrs;
//        overrides hazard since ID instr is wrong-path).
//     2. hazard: load_pc=0, load_if_id=0, load_id_ex=1 with bubble_id_ex=1, load_ex_mem=1,
//        load_mem_wb=1. Exactly one bubble; next cycle load is in MEM, hazard clears.
//        Fetch is re-issued at the held PC (flags cleared).
//     3. else: all load_*=1, flush/bubble 0.
//   advance=0: all load_*, flush, bubble = 0; stall=1; next state STALL;
//     i_done_q <= i_done_q | imem_resp; d_done_q <= d_done_q | (dmem_req & dmem_resp).
//   advance=1: next state RUN; i_done_q, d_done_q <= 0.
//   Simultaneous imem_resp and dmem_resp in one cycle -> advance that cycle, no extra stall.
//   I-miss and D-miss overlapping: each response recorded once; advance on later of the two.
//   ex_br_taken and inputs must be held by datapath while stall=1 (regs don't load).
//   Reset mid-stall: flags cleared, state RUN, partially completed accesses discarded.
// CONFIGURATION
//   `PIPE_PERF_EN defined: extra outputs perf_stall_cycles, perf_bubbles, perf_flushes
//     (CNT_W each, reset 0, wrap on overflow), incremented on stall=1, hazard bubble, branch flush.
//   Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//   imem_resp=1, dmem_req=0 every cycle, no hazards -> all load_*=1 each cycle, stall=0.
//   EX: ex_mem_read=1 ex_rd=5; ID: id_uses_rs1=1 id_rs1=5 -> one cycle load_pc=0,
//     load_if_id=0, bubble_id_ex=1; next cycle (ex_mem_read=0) all loads 1.
//   Same but ex_rd=0 -> no bubble, all loads 1.
//   dmem_req=1, imem_resp at cycle 1, dmem_resp at cycle 4 -> stall=1 cycles 0-3, imem_read=0
//     cycles 2-4, all loads 1 at cycle 4.
//   ex_br_taken=1 with hazard=1 -> flush_if_id=1, bubble_id_ex=1, load_pc=1 (branch wins).
//   reset asserted during D-miss stall -> outputs 0; after release imem_read=1, i_done_q=0,
//     `PIPE_PERF_EN: perf_stall_cycles=0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake and register-index bundle between the pipeline datapath and the hazard controller.
// The master is the datapath side; the slave is the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic                  imem_resp;
  logic                  dmem_req;
  logic                  dmem_resp;
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_uses_rs1;
  logic                  id_uses_rs2;
  logic                  ex_mem_read;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_br_taken;

  logic imem_read;
  logic load_pc;
  logic load_if_id;
  logic load_id_ex;
  logic load_ex_mem;
  logic load_mem_wb;
  logic flush_if_id;
  logic bubble_id_ex;
  logic stall;

  modport master (
    output imem_resp, dmem_req, dmem_resp, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd, ex_br_taken,
    input  imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, bubble_id_ex, stall
  );

  modport slave (
    input  imem_resp, dmem_req, dmem_resp, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_mem_read, ex_rd, ex_br_taken,
    output imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
           flush_if_id, bubble_id_ex, stall
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline register load/flush/bubble control for a 5-stage pipeline with cache-miss stalls.
// Optional perf counters are enabled by defining PIPE_PERF_EN.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 5
`ifdef PIPE_PERF_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_hazard_ctrl_if.slave  hz
`ifdef PIPE_PERF_EN
  , output logic [CNT_W-1:0]     perf_stall_cycles
  , output logic [CNT_W-1:0]     perf_bubbles
  , output logic [CNT_W-1:0]     perf_flushes
`endif
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] STALL = 1'b1;

  localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

  logic [0:0] state_q;
  logic       i_done_q;
  logic       d_done_q;

  logic i_ok;
  logic d_ok;
  logic advance;
  logic hazard;
  logic take_br;
  logic take_hz;

  // Done flags are only ever set while stalled, so gating by state is equivalent.
  always_comb begin
    i_ok    = hz.imem_resp | ((state_q == STALL) & i_done_q);
    d_ok    = ~hz.dmem_req | hz.dmem_resp | ((state_q == STALL) & d_done_q);
    advance = i_ok & d_ok;
    hazard  = hz.ex_mem_read & (hz.ex_rd != REG_X0) &
              ((hz.id_uses_rs1 & (hz.id_rs1 == hz.ex_rd)) |
               (hz.id_uses_rs2 & (hz.id_rs2 == hz.ex_rd)));
    take_br = ~reset & advance & hz.ex_br_taken;
    take_hz = ~reset & advance & ~hz.ex_br_taken & hazard;
  end

  always_comb begin
    hz.imem_read    = 1'b0;
    hz.load_pc      = 1'b0;
    hz.load_if_id   = 1'b0;
    hz.load_id_ex   = 1'b0;
    hz.load_ex_mem  = 1'b0;
    hz.load_mem_wb  = 1'b0;
    hz.flush_if_id  = 1'b0;
    hz.bubble_id_ex = 1'b0;
    hz.stall        = 1'b0;
    if (!reset) begin
      hz.imem_read = ~i_done_q;
      hz.stall     = ~advance;
      if (advance) begin
        hz.load_id_ex  = 1'b1;
        hz.load_ex_mem = 1'b1;
        hz.load_mem_wb = 1'b1;
        // A taken branch kills the ID instruction, so it beats the load-use bubble.
        if (take_br) begin
          hz.load_pc      = 1'b1;
          hz.load_if_id   = 1'b1;
          hz.flush_if_id  = 1'b1;
          hz.bubble_id_ex = 1'b1;
        end else if (take_hz) begin
          hz.bubble_id_ex = 1'b1;
        end else begin
          hz.load_pc    = 1'b1;
          hz.load_if_id = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else if (advance) begin
      state_q  <= RUN;
      i_done_q <= 1'b0;
      d_done_q <= 1'b0;
    end else begin
      state_q  <= STALL;
      i_done_q <= i_done_q | hz.imem_resp;
      d_done_q <= d_done_q | (hz.dmem_req & hz.dmem_resp);
    end
  end

`ifdef PIPE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_bubbles      <= '0;
      perf_flushes      <= '0;
    end else begin
      if (hz.stall) perf_stall_cycles <= perf_stall_cycles + 1'b1;
      if (take_hz)  perf_bubbles      <= perf_bubbles + 1'b1;
      if (take_br)  perf_flushes      <= perf_flushes + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl: stimulus pushes hand-computed
// output vectors, a monitor pops and compares one per cycle.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_ADDR_W(5)) hz ();

`ifdef PIPE_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_bubbles;
  logic [31:0] perf_flushes;
`endif

  pipeline_hazard_ctrl #(
    .REG_ADDR_W(5)
`ifdef PIPE_PERF_EN
    , .CNT_W(32)
`endif
  ) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz.slave)
`ifdef PIPE_PERF_EN
    , .perf_stall_cycles (perf_stall_cycles)
    , .perf_bubbles      (perf_bubbles)
    , .perf_flushes      (perf_flushes)
`endif
  );

  // Vector bits: imem_read, load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
  // flush_if_id, bubble_id_ex, stall.
  localparam logic [8:0] E_ZERO  = 9'b0_00000_00_0;
  localparam logic [8:0] E_RUN   = 9'b1_11111_00_0;
  localparam logic [8:0] E_HAZ   = 9'b1_00111_01_0;
  localparam logic [8:0] E_BR    = 9'b1_11111_11_0;
  localparam logic [8:0] E_STF   = 9'b1_00000_00_1;
  localparam logic [8:0] E_STN   = 9'b0_00000_00_1;
  localparam logic [8:0] E_RUNNF = 9'b0_11111_00_0;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic step(input logic rst, input logic ir, input logic dq, input logic dr,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                      input logic u2, input logic mr, input logic [4:0] rd, input logic br,
                      input logic [8:0] exp, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset          = rst;
    hz.imem_resp   = ir;
    hz.dmem_req    = dq;
    hz.dmem_resp   = dr;
    hz.id_rs1      = rs1;
    hz.id_rs2      = rs2;
    hz.id_uses_rs1 = u1;
    hz.id_uses_rs2 = u2;
    hz.ex_mem_read = mr;
    hz.ex_rd       = rd;
    hz.ex_br_taken = br;
    e.exp  = exp;
    e.name = name;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t       e;
    logic [8:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e   = q.pop_front();
        act = {hz.imem_read, hz.load_pc, hz.load_if_id, hz.load_id_ex, hz.load_ex_mem,
               hz.load_mem_wb, hz.flush_if_id, hz.bubble_id_ex, hz.stall};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %b expected %b", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin : stim
    int waited;
    hz.imem_resp = 1'b0; hz.dmem_req = 1'b0; hz.dmem_resp = 1'b0;
    hz.id_rs1 = '0; hz.id_rs2 = '0; hz.id_uses_rs1 = 1'b0; hz.id_uses_rs2 = 1'b0;
    hz.ex_mem_read = 1'b0; hz.ex_rd = '0; hz.ex_br_taken = 1'b0;

    //   rst ir dq dr rs1 rs2 u1 u2 mr rd br
    step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO,  "reset_outputs");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "run_plain");
    step(0, 1, 0, 0, 3, 4, 1, 1, 1, 5, 0, E_RUN,   "load_no_match");
    step(0, 1, 0, 0, 5, 0, 1, 0, 1, 5, 0, E_HAZ,   "hazard_rs1");
    step(0, 1, 0, 0, 5, 0, 1, 0, 0, 5, 0, E_RUN,   "hazard_cleared");
    step(0, 1, 0, 0, 1, 7, 0, 1, 1, 7, 0, E_HAZ,   "hazard_rs2");
    step(0, 1, 0, 0, 9, 2, 0, 0, 1, 9, 0, E_RUN,   "match_but_unused");
    step(0, 1, 0, 0, 0, 0, 1, 1, 1, 0, 0, E_RUN,   "x0_no_hazard");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_BR,    "branch_flush");
    step(0, 1, 0, 0, 5, 0, 1, 0, 1, 5, 1, E_BR,    "branch_over_hazard");
    // D-miss with I response at cycle 1, D response at cycle 4
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_STF,   "dmiss_c0");
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_STF,   "dmiss_c1");
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_STN,   "dmiss_c2");
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_STN,   "dmiss_c3");
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_RUNNF, "dmiss_c4");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "after_dmiss");
    step(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "simultaneous_resp");
    // D response first, I response later
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_STF,   "overlap_d_first");
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "overlap_i_later");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_STF,   "imiss_branch_held");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, E_BR,    "branch_after_imiss");
    step(0, 0, 0, 0, 6, 0, 1, 0, 1, 6, 0, E_STF,   "imiss_hazard_held");
    step(0, 1, 0, 0, 6, 0, 1, 0, 1, 6, 0, E_HAZ,   "hazard_after_imiss");
    // Reset during a D-miss stall after the I response was recorded
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_STF,   "pre_reset_c0");
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_STN,   "pre_reset_c1");
    step(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_ZERO,  "reset_mid_stall");
    step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_STF,   "post_reset_fetch");
`ifdef PIPE_PERF_EN
    @(negedge clk);
    checks++;
    if (perf_stall_cycles !== 32'd0) begin
      errors++;
      $display("FAIL perf_after_reset: got %0d expected 0", perf_stall_cycles);
    end
`endif
    step(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, E_STF,   "post_reset_d_done");
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, E_RUN,   "post_reset_advance");

    waited = 0;
    while (q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
    end
    @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
